// File: rtl/signal_types_pkg.sv
// signal_types_pkg: shared ADC capture types and constants.
// Sample layout, capture FSM states and trigger modes.
package signal_types_pkg;

  localparam int SAMPLE_W = 12;

  typedef struct packed {
    logic [3:0]          unused1;
    logic [SAMPLE_W-1:0] ch1;
    logic [3:0]          unused0;
    logic [SAMPLE_W-1:0] ch0;
  } adc_sample_t;

  typedef enum logic [2:0] {
    CAP_IDLE,
    CAP_ARM,
    CAP_WAIT_TRIG,
    CAP_POST,
    CAP_DONE
  } cap_state_e;

  typedef enum logic [1:0] {
    TRIG_IMM,
    TRIG_RISE,
    TRIG_FALL,
    TRIG_EXT
  } cap_trig_mode_e;

  function automatic logic cap_active(cap_state_e s);
    return (s == CAP_ARM) || (s == CAP_WAIT_TRIG) ||
           (s == CAP_POST);
  endfunction

endpackage

// File: rtl/cap_trig_detect.sv
// cap_trig_detect: threshold crossing and external edge trigger.
// Keeps the previous taken ch0 and a latched ext rising edge.
module cap_trig_detect
  import signal_types_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                take,
  input  logic                clr,
  input  logic [1:0]          mode,
  input  logic [SAMPLE_W-1:0] level,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                ext,
  output logic                hit
);

  logic [SAMPLE_W-1:0] prev_ch0;
  logic                ext_q;
  logic                ext_seen;
  logic                ext_edge;
  logic                below_prev;
  logic                below_cur;

  assign ext_edge   = ext & ~ext_q;
  assign below_prev = prev_ch0 < level;
  assign below_cur  = sample < level;

  // trigger condition for the current take
  always_comb begin
    hit = 1'b0;
    unique case (cap_trig_mode_e'(mode))
      TRIG_IMM:  hit = take;
      TRIG_RISE: hit = take & below_prev & ~below_cur;
      TRIG_FALL: hit = take & ~below_prev & below_cur;
      TRIG_EXT:  hit = take & (ext_seen | ext_edge);
      default:   hit = 1'b0;
    endcase
  end

  // previous sample and ext edge latch; a take consumes the latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_ch0 <= '0;
      ext_q    <= 1'b0;
      ext_seen <= 1'b0;
    end else begin
      ext_q <= ext;
      if (take)
        prev_ch0 <= sample;
      if (take)
        ext_seen <= 1'b0;
      else if (ext_edge)
        ext_seen <= 1'b1;
      else if (clr)
        ext_seen <= 1'b0;
    end
  end

endmodule

// File: rtl/adc_capture_writer.sv
// adc_capture_writer: triggered two-channel ADC capture engine.
// Decimates, fills a pre-trigger ring and writes the window to two RAMs.
module adc_capture_writer
  import signal_types_pkg::*;
#(
  parameter int ADDR_WIDTH  = 11,
  parameter int DATA_WIDTH  = 16,
  parameter int DECIM_WIDTH = 8
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic [31:0]            adc_sample_i,
  input  logic                   adc_vld_i,
  input  logic                   cap_start_i,
  input  logic                   cap_abort_i,
  input  logic [ADDR_WIDTH:0]    cap_len_i,
  input  logic [ADDR_WIDTH-1:0]  cap_pre_i,
  input  logic [DECIM_WIDTH-1:0] cap_decim_i,
  input  logic [1:0]             trig_mode_i,
  input  logic [SAMPLE_W-1:0]    trig_level_i,
  input  logic                   trig_ext_i,
  output logic                   mem_we_o,
  output logic [ADDR_WIDTH-1:0]  mem_addr_o,
  output logic [DATA_WIDTH-1:0]  mem_din0_o,
  output logic [DATA_WIDTH-1:0]  mem_din1_o,
  output logic                   cap_busy_o,
  output logic                   cap_done_o,
  output logic [ADDR_WIDTH-1:0]  cap_trig_addr_o
);

  localparam int LW = ADDR_WIDTH + 1;

  adc_sample_t smp;
  logic        sample_unused;

  assign smp           = adc_sample_i;
  assign sample_unused = ^{smp.unused1, smp.unused0};

  cap_state_e state_q;
  cap_state_e state_d;
  cap_state_e c_state;

  logic                   start_q;
  logic                   start_edge;
  logic                   start_acc;
  logic                   busy;
  logic                   done_d;

  logic [LW-1:0]          len_l;
  logic [LW-1:0]          pre_l;
  logic [DECIM_WIDTH-1:0] decim_l;
  logic [1:0]             mode_l;
  logic [SAMPLE_W-1:0]    level_l;

  logic [LW-1:0]          len_n;
  logic [LW-1:0]          pre_x;
  logic [LW-1:0]          pre_n;

  logic [LW-1:0]          c_len;
  logic [LW-1:0]          c_pre;
  logic [DECIM_WIDTH-1:0] c_decim;
  logic [1:0]             c_mode;
  logic [SAMPLE_W-1:0]    c_level;
  logic [ADDR_WIDTH-1:0]  c_wptr;
  logic [LW-1:0]          c_fill;

  logic [DECIM_WIDTH-1:0] decim_cnt;
  logic [ADDR_WIDTH-1:0]  wptr_q;
  logic [LW-1:0]          fill_q;
  logic [LW-1:0]          fill_inc;
  logic [LW-1:0]          post_q;
  logic [LW-1:0]          post_init;
  logic [ADDR_WIDTH-1:0]  trig_addr_q;

  logic                   take;
  logic                   tk;
  logic                   hit;

  logic                   we_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  din0_q;
  logic [DATA_WIDTH-1:0]  din1_q;

  assign start_edge = cap_start_i & ~start_q;
  assign start_acc  = start_edge & ~cap_abort_i & ~busy;

  assign len_n = (cap_len_i == '0) ? LW'(1) : cap_len_i;
  assign pre_x = {1'b0, cap_pre_i};
  assign pre_n = (pre_x >= len_n) ? len_n - LW'(1) : pre_x;

  // the start-edge cycle runs on the freshly latched settings
  assign c_len   = start_acc ? len_n        : len_l;
  assign c_pre   = start_acc ? pre_n        : pre_l;
  assign c_decim = start_acc ? cap_decim_i  : decim_l;
  assign c_mode  = start_acc ? trig_mode_i  : mode_l;
  assign c_level = start_acc ? trig_level_i : level_l;
  assign c_wptr  = start_acc ? '0           : wptr_q;
  assign c_fill  = start_acc ? '0           : fill_q;
  assign c_state = start_acc ?
                   ((pre_n == '0) ? CAP_WAIT_TRIG : CAP_ARM) :
                   state_q;

  assign take = adc_vld_i & (start_acc | (decim_cnt == '0));
  assign tk   = take & cap_active(c_state) & ~cap_abort_i;

  assign fill_inc  = c_fill + LW'(1);
  assign post_init = c_len - c_pre - LW'(1);

  cap_trig_detect u_trig (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .take   (tk),
    .clr    (start_acc),
    .mode   (c_mode),
    .level  (c_level),
    .sample (smp.ch0),
    .ext    (trig_ext_i),
    .hit    (hit)
  );

  // FSM state register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      state_q <= CAP_IDLE;
    else
      state_q <= state_d;
  end

  // FSM next state, advanced only by takes
  always_comb begin
    state_d = c_state;
    if (cap_abort_i) begin
      state_d = CAP_IDLE;
    end else if (tk) begin
      unique case (c_state)
        CAP_ARM:
          if (fill_inc == c_pre)
            state_d = CAP_WAIT_TRIG;
        CAP_WAIT_TRIG:
          if (hit)
            state_d = (post_init == '0) ? CAP_DONE : CAP_POST;
        CAP_POST:
          if (post_q == LW'(1))
            state_d = CAP_DONE;
        default: ;
      endcase
    end
  end

  // FSM outputs; done lands one cycle after the last write
  always_comb begin
    busy   = 1'b0;
    done_d = 1'b0;
    unique case (state_q)
      CAP_ARM, CAP_WAIT_TRIG, CAP_POST:
        busy = 1'b1;
      CAP_DONE:
        done_d = ~cap_abort_i & ~start_edge;
      default: ;
    endcase
  end

  // control latch, decimation and window counters
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      start_q     <= 1'b0;
      len_l       <= '0;
      pre_l       <= '0;
      decim_l     <= '0;
      mode_l      <= '0;
      level_l     <= '0;
      decim_cnt   <= '0;
      wptr_q      <= '0;
      fill_q      <= '0;
      post_q      <= '0;
      trig_addr_q <= '0;
      cap_done_o  <= 1'b0;
    end else begin
      start_q    <= cap_start_i;
      cap_done_o <= done_d;
      if (start_acc) begin
        len_l   <= len_n;
        pre_l   <= pre_n;
        decim_l <= cap_decim_i;
        mode_l  <= trig_mode_i;
        level_l <= trig_level_i;
      end
      if (take)
        decim_cnt <= c_decim;
      else if (start_acc)
        decim_cnt <= '0;
      else if (adc_vld_i)
        decim_cnt <= decim_cnt - DECIM_WIDTH'(1);
      wptr_q <= c_wptr + ADDR_WIDTH'(tk);
      fill_q <= (tk && c_state == CAP_ARM) ? fill_inc : c_fill;
      if (tk && c_state == CAP_WAIT_TRIG && hit) begin
        trig_addr_q <= c_wptr;
        post_q      <= post_init;
      end else if (tk && c_state == CAP_POST) begin
        post_q <= post_q - LW'(1);
      end
    end
  end

  // registered RAM write port shared by both channels
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      din0_q <= '0;
      din1_q <= '0;
    end else begin
      we_q <= tk;
      if (tk) begin
        addr_q <= c_wptr;
        din0_q <= DATA_WIDTH'(smp.ch0);
        din1_q <= DATA_WIDTH'(smp.ch1);
      end
    end
  end

  assign mem_we_o        = we_q;
  assign mem_addr_o      = addr_q;
  assign mem_din0_o      = din0_q;
  assign mem_din1_o      = din1_q;
  assign cap_busy_o      = busy;
  assign cap_trig_addr_o = trig_addr_q;

endmodule

// File: tb/tb_adc_capture_writer.sv
// tb_adc_capture_writer: randomized bench for adc_capture_writer.
// Windows are predicted from the logged stimulus, not from DUT state.
module tb_adc_capture_writer;

  localparam int AW = 4;
  localparam int DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] adc_sample;
  logic        vld;
  logic        start;
  logic        abort;
  logic [AW:0] cap_len;
  logic [AW-1:0] cap_pre;
  logic [7:0]  cap_decim;
  logic [1:0]  trig_mode;
  logic [11:0] trig_level;
  logic        ext;
  logic        we;
  logic [AW-1:0] addr;
  logic [15:0] din0;
  logic [15:0] din1;
  logic        busy;
  logic        done;
  logic [AW-1:0] trig_addr;

  logic [15:0] ram0 [DEPTH];
  logic [15:0] ram1 [DEPTH];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adc_capture_writer #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (16),
    .DECIM_WIDTH (8)
  ) dut (
    .sys_clk         (clk),
    .sys_rst_n       (rst_n),
    .adc_sample_i    (adc_sample),
    .adc_vld_i       (vld),
    .cap_start_i     (start),
    .cap_abort_i     (abort),
    .cap_len_i       (cap_len),
    .cap_pre_i       (cap_pre),
    .cap_decim_i     (cap_decim),
    .trig_mode_i     (trig_mode),
    .trig_level_i    (trig_level),
    .trig_ext_i      (ext),
    .mem_we_o        (we),
    .mem_addr_o      (addr),
    .mem_din0_o      (din0),
    .mem_din1_o      (din1),
    .cap_busy_o      (busy),
    .cap_done_o      (done),
    .cap_trig_addr_o (trig_addr)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cap_run(input int l, input int p, input int d,
                         input int m, input int lv, input int pat,
                         input int base, input int step, input int vpct,
                         input int ext_at, input bit hold,
                         input int budget);
    bit          lg_v[$];
    logic [11:0] lg_c0[$];
    logic [11:0] lg_c1[$];
    bit          lg_e[$];
    int          w_a[$];
    logic [15:0] w_d0[$];
    logic [15:0] w_d1[$];
    int          tc[$];
    logic [11:0] t0[$];
    logic [11:0] t1[$];
    int ln, pn, k, n, cnt, done_it, stop_it, last_obs, vcount, lo, lw;
    bit ep, fire, exp_done, done_end, busy_end, v, e;
    logic [11:0] c0, c1;
    @(negedge clk);
    start = 0; vld = 0; ext = 0; abort = 0;
    cap_len = (AW+1)'(l); cap_pre = AW'(p); cap_decim = 8'(d);
    trig_mode = 2'(m); trig_level = 12'(lv);
    ep = 0; done_it = -1; stop_it = budget; vcount = 0;
    last_obs = budget; done_end = 0; busy_end = 1;
    for (int c = 0; c <= budget; c++) begin
      @(negedge clk);
      if (c > 0 && we) begin
        w_a.push_back(int'(addr));
        w_d0.push_back(din0);
        w_d1.push_back(din1);
        ram0[addr] = din0;
        ram1[addr] = din1;
      end
      if (c > 0 && done && done_it < 0) begin
        done_it = c;
        stop_it = c + 2;
      end
      if (c >= stop_it) begin
        last_obs = c; done_end = done; busy_end = busy;
        break;
      end
      v = ($urandom_range(99) < vpct);
      c0 = (pat == 1) ? 12'(base + step * vcount) : 12'($urandom);
      c1 = 12'($urandom);
      if (v) vcount++;
      if (ext_at >= 0) e = (c == ext_at) || (c == ext_at + 1);
      else if (ext_at == -2) e = ep ^ ($urandom_range(7) == 0);
      else e = 0;
      adc_sample = {4'($urandom), c1, 4'($urandom), c0};
      vld = v; ext = e; start = (c == 0) || hold;
      lg_v.push_back(v); lg_c0.push_back(c0);
      lg_c1.push_back(c1); lg_e.push_back(e);
      ep = e;
    end
    start = 0; vld = 0; ext = 0;
    // reference: normalise, decimate, locate trigger
    ln = (l == 0) ? 1 : l;
    pn = (p >= ln) ? ln - 1 : p;
    cnt = 0;
    for (int c = 0; c < lg_v.size(); c++) begin
      if (lg_v[c]) begin
        if (cnt == 0) begin
          tc.push_back(c); t0.push_back(lg_c0[c]);
          t1.push_back(lg_c1[c]); cnt = d;
        end else cnt--;
      end
    end
    k = -1;
    for (int i = pn; i < tc.size() && k < 0; i++) begin
      fire = 0;
      case (m)
        0: fire = 1;
        1: fire = (i > 0) && (t0[i-1] < lv) && (t0[i] >= lv);
        2: fire = (i > 0) && (t0[i-1] >= lv) && (t0[i] < lv);
        default:
          for (int c = (i == 0) ? 0 : tc[i-1] + 1; c <= tc[i]; c++)
            if (lg_e[c] && (c == 0 || !lg_e[c-1])) fire = 1;
      endcase
      if (fire) k = i;
    end
    n = k + ln - pn;
    exp_done = (k >= 0) && (n <= tc.size()) &&
               (tc[n-1] + 2 <= last_obs);
    if (exp_done) begin
      chk("n_wr", 32'(w_a.size()), 32'(n));
      lo = (w_a.size() < n) ? w_a.size() : n;
      for (int i = 0; i < lo; i++) begin
        chk("wr_addr", 32'(w_a[i]), 32'(i % DEPTH));
        chk("wr_d0", 32'(w_d0[i]), 32'(t0[i]));
        chk("wr_d1", 32'(w_d1[i]), 32'(t1[i]));
      end
      chk("trig_addr", 32'(trig_addr), 32'(k % DEPTH));
      chk("done_at", 32'(done_it), 32'(tc[n-1] + 2));
      chk("done_hold", 32'(done_end), 32'd1);
      chk("busy_end", 32'(busy_end), 32'd0);
      for (int j = 0; j < ln; j++) begin
        lw = (k - pn + j) % DEPTH;
        chk("win0", 32'(ram0[lw]), 32'(t0[k-pn+j]));
        chk("win1", 32'(ram1[lw]), 32'(t1[k-pn+j]));
      end
    end else begin
      chk("no_done", 32'(done_it < 0), 32'd1);
      lo = (w_a.size() < tc.size()) ? w_a.size() : tc.size();
      for (int i = 0; i < lo; i++)
        chk("wr_d0_nt", 32'(w_d0[i]), 32'(t0[i]));
      abort = 1;
      @(negedge clk);
      abort = 0;
      chk("abort_idle", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] hold_ta;
    int l, p, d, m;
    rst_n = 0; adc_sample = 0; vld = 0; start = 0; abort = 0;
    cap_len = 0; cap_pre = 0; cap_decim = 0; trig_mode = 0;
    trig_level = 0; ext = 0;
    repeat (2) @(negedge clk);
    chk("rst_out", 32'({we, addr, busy, done, trig_addr}), 32'd0);
    chk("rst_din", 32'({din0, din1}), 32'd0);
    rst_n = 1;

    // immediate trigger, ramp data
    cap_run(8, 0, 0, 0, 0, 1, 0, 1, 100, -1, 0, 200);
    // decimation by four
    cap_run(4, 0, 3, 0, 0, 1, 0, 1, 100, -1, 0, 200);
    // rising threshold with pre-trigger
    cap_run(16, 4, 0, 1, 12'h800, 1, 12'h700, 12'h10, 100, -1, 0, 200);
    // ring wrap, external trigger after 40 takes
    cap_run(16, 8, 0, 3, 0, 1, 0, 1, 100, 40, 0, 200);

    // abort while waiting for a trigger
    @(negedge clk);
    cap_len = 8; cap_pre = 2; cap_decim = 0; trig_mode = 3; ext = 0;
    @(negedge clk);
    start = 1; vld = 1; adc_sample = $urandom;
    repeat (6) begin
      @(negedge clk);
      adc_sample = $urandom;
    end
    hold_ta = trig_addr;
    chk("abort_busy_pre", 32'(busy), 32'd1);
    abort = 1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_we", 32'(we), 32'd0);
    chk("abort_ta", 32'(trig_addr), 32'(hold_ta));
    abort = 0; start = 0; vld = 0;
    @(negedge clk);
    chk("abort_stay", 32'({busy, we}), 32'd0);
    cap_run(8, 2, 0, 0, 0, 0, 0, 0, 100, -1, 0, 200);

    // reset during POST
    @(negedge clk);
    cap_len = 16; cap_pre = 3; cap_decim = 0; trig_mode = 0;
    @(negedge clk);
    start = 1; vld = 1; adc_sample = $urandom;
    repeat (8) @(negedge clk);
    chk("post_busy", 32'(busy), 32'd1);
    chk("post_ta", 32'(trig_addr), 32'd3);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_out", 32'({we, addr, busy, done, trig_addr}), 32'd0);
    chk("mid_rst_din", 32'({din0, din1}), 32'd0);
    @(negedge clk);
    start = 0; vld = 0; rst_n = 1;

    // edge cases
    cap_run(0, 0, 0, 0, 0, 0, 0, 0, 100, -1, 0, 100);
    cap_run(5, 9, 0, 0, 0, 1, 100, 3, 100, -1, 0, 100);
    cap_run(6, 2, 1, 0, 0, 0, 0, 0, 100, -1, 1, 100);
    cap_run(4, 1, 3, 3, 0, 1, 0, 1, 100, 6, 0, 100);

    // randomized windows
    for (int r = 0; r < 30; r++) begin
      l = $urandom_range(16);
      p = $urandom_range(15);
      d = $urandom_range(3);
      m = $urandom_range(3);
      if (m == 1 || m == 2) begin
        if (l < 2) l = 2;
        if (p == 0) p = 1;
      end
      cap_run(l, p, d, m, $urandom_range(4095), $urandom_range(1),
              $urandom_range(4095), $urandom_range(1, 64),
              $urandom_range(40, 100), (m == 3) ? -2 : -1,
              $urandom_range(1) == 1, 400);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
